// File: rtl/instr_realign_expand.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : instr_realign_expand                                           |
// | Brief   : Fetch-word to instruction realigner with halfword FIFO;        |
// |           optional RVC expansion under `RVC_EXPAND_EN.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_realign_expand #(
  parameter int FETCH_W = 32,
  parameter int BUF_HW  = 6,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FETCH_W-1:0] in_data,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_is_c,
  output logic               out_illegal
);

  localparam int c_NHW = FETCH_W / 16;
  localparam int c_DW  = (c_NHW > 2) ? 2 : 1;
  localparam int c_CW  = $clog2(BUF_HW + 1);

  logic [15:0]     r_hw [BUF_HW];
  logic [c_CW-1:0] r_cnt;
  logic [PC_W-1:0] r_head_pc;
  logic [c_DW-1:0] r_drop;

  logic [15:0] w_in_hw  [c_NHW];
  logic [15:0] w_hw_nxt [BUF_HW];
  logic        w_is_c;
  logic        w_push;
  logic        w_pop;
  int          w_cnt;
  int          w_drop_n;
  int          w_pop_n;
  int          w_push_n;
  int          w_base;

  generate
    for (genvar g = 0; g < c_NHW; g++) begin : g_in_hw
      assign w_in_hw[g] = in_data[16*g +: 16];
    end
  endgenerate

  assign w_cnt    = int'(r_cnt);
  assign w_drop_n = int'(r_drop);
  assign w_is_c   = (r_hw[0][1:0] != 2'b11);

  // in_ready looks only at registered occupancy, never at a same-cycle pop.
  assign in_ready  = ((BUF_HW - w_cnt) >= c_NHW);
  assign out_valid = !redirect && (((w_cnt >= 1) && w_is_c) || (w_cnt >= 2));
  assign w_push    = in_valid && in_ready && !redirect;
  assign w_pop     = out_valid && out_ready;
  assign w_pop_n   = w_pop ? (w_is_c ? 1 : 2) : 0;
  assign w_push_n  = w_push ? (c_NHW - w_drop_n) : 0;
  assign w_base    = w_cnt - w_pop_n;

  // Shift surviving halfwords down by the pop amount, then append the
  // non-dropped halfwords of the incoming word behind them.
  always_comb begin
    for (int i = 0; i < BUF_HW; i++) begin
      w_hw_nxt[i] = r_hw[i];
      for (int s = 0; s < BUF_HW; s++) begin
        if ((s == i + w_pop_n) && (s < w_cnt)) begin
          w_hw_nxt[i] = r_hw[s];
        end
      end
      for (int k = 0; k < c_NHW; k++) begin
        if (w_push && (k >= w_drop_n) && (i == w_base + k - w_drop_n)) begin
          w_hw_nxt[i] = w_in_hw[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_head_pc <= '0;
      r_drop    <= '0;
    end else if (redirect) begin
      r_cnt     <= '0;
      r_head_pc <= redirect_pc;
      r_drop    <= redirect_pc[c_DW:1];
    end else begin
      r_cnt <= c_CW'(w_cnt + w_push_n - w_pop_n);
      if (w_push && (r_cnt == '0)) begin
        r_head_pc <= in_pc + PC_W'(2 * w_drop_n);
      end else begin
        r_head_pc <= r_head_pc + PC_W'(2 * w_pop_n);
      end
      if (w_push) begin
        r_drop <= '0;
      end
    end
  end

  // Data storage needs no reset; r_cnt qualifies which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BUF_HW; i++) begin
      r_hw[i] <= w_hw_nxt[i];
    end
  end

  assign out_pc   = r_head_pc;
  assign out_is_c = w_is_c;

`ifdef RVC_EXPAND_EN
  // Returns {illegal, instr} for a 16-bit encoding.
  function automatic logic [32:0] f_expand(input logic [15:0] hw);
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    imm = {{6{hw[12]}}, hw[12], hw[6:2]};
    rd  = hw[11:7];
    rs2 = hw[6:2];
    f_expand = {1'b1, 16'b0, hw};
    if (hw[1:0] == 2'b01 && hw[15:13] == 3'b000) begin
      f_expand = {1'b0, imm, rd, 3'b000, rd, 7'b0010011};
    end else if (hw[1:0] == 2'b01 && hw[15:13] == 3'b010) begin
      f_expand = {1'b0, imm, 5'd0, 3'b000, rd, 7'b0010011};
    end else if (hw[1:0] == 2'b10 && hw[15:12] == 4'b1000 && rs2 != 5'd0) begin
      f_expand = {1'b0, 7'b0, rs2, 5'd0, 3'b000, rd, 7'b0110011};
    end else if (hw[1:0] == 2'b10 && hw[15:12] == 4'b1001 && rs2 != 5'd0) begin
      f_expand = {1'b0, 7'b0, rs2, rd, 3'b000, rd, 7'b0110011};
    end
  endfunction

  logic [32:0] w_exp;
  assign w_exp = f_expand(r_hw[0]);

  always_comb begin
    if (w_is_c) begin
      out_instr   = w_exp[31:0];
      out_illegal = w_exp[32];
    end else begin
      out_instr   = {r_hw[1], r_hw[0]};
      out_illegal = 1'b0;
    end
  end
`else
  assign out_instr   = w_is_c ? {16'b0, r_hw[0]} : {r_hw[1], r_hw[0]};
  assign out_illegal = 1'b0;
`endif

endmodule
`default_nettype wire
